mips_timer: RTL and testbench
=============================

MIPS_TIMER -- requirements
Module: mips_timer

Interface
REQ-001 clk  in  1  rising-edge clock shared with the CPU pipeline.
REQ-002 reset  in  1  synchronous, active-low reset; 0 at a rising clk edge resets the block.
REQ-003 memwrite  in  1  data-bus write strobe, driven by the CPU MEM stage.
REQ-004 memaddr  in  32  data-bus byte address; bits [1:0] ignored.
REQ-005 memwritedata  in  32  data-bus write data.
REQ-006 memreaddata  out  32  combinational read data for the addressed register.
REQ-007 hit  out  1  combinational; 1 when memaddr[31:4] == 28'hFFFF100, used by the system read mux.
REQ-008 irq  out  1  registered interrupt request to the system.

Function
REQ-009 Register map, base 0xFFFF1000: 0x0 CTRL, 0x4 LOAD, 0x8 COUNT (read-only), 0xC STATUS.
REQ-010 CTRL fields: bit0 EN, bit1 AUTORELOAD, bit2 IE, bits[15:8] PRE; all other bits read 0, writes to them ignored.
REQ-011 Register write occurs at the rising edge when memwrite=1 and hit=1; memaddr[3:2] selects the register.
REQ-012 Writing LOAD sets LOAD and COUNT to memwritedata and clears the 8-bit prescaler counter psc in the same edge.
REQ-013 Writes to COUNT are ignored.
REQ-014 STATUS bit0 EXPIRED is write-1-to-clear; writing 0 has no effect; other STATUS bits read 0.
REQ-015 Reads are combinational: hit=1 returns the selected register; hit=0 returns memreaddata=0.
REQ-016 Prescaler: EN=0 forces psc=0 and generates no ticks; with EN=1, psc==PRE generates a tick and sets psc=0, otherwise psc increments.
REQ-017 Tick with COUNT!=0 sets COUNT=COUNT-1.
REQ-018 Tick with COUNT==0 sets EXPIRED=1; with AUTORELOAD=1, COUNT=LOAD; with AUTORELOAD=0, COUNT stays 0 and EN clears to 0.
REQ-019 Expiry period = (LOAD+1)*(PRE+1) clocks from the EN=1 write edge to the EXPIRED set edge.
REQ-020 irq registers (EXPIRED_next & IE_next), so irq rises on the same edge that sets EXPIRED when IE=1.
REQ-021 Tick decisions use register values from before the edge; a CPU write in the same cycle applies its new values at that edge.
REQ-022 A LOAD write overrides a same-cycle tick: COUNT takes the written value and EXPIRED is not set by that tick.
REQ-023 A same-cycle EXPIRED set and STATUS clear write: set wins, EXPIRED=1.
REQ-024 A CTRL write clearing EN in the same cycle as a tick: the tick still applies (old EN=1), and EN reads 0 afterward.
REQ-025 LOAD=0 with PRE=0 and AUTORELOAD=1 expires on every clock.
REQ-026 COUNT arithmetic is 32-bit unsigned; no underflow below 0.

Reset
REQ-027 reset=0 at an edge sets CTRL=0, LOAD=0, COUNT=0, psc=0, EXPIRED=0, irq=0.
REQ-028 reset overrides any same-cycle write or tick, including mid-countdown.
REQ-029 memreaddata and hit stay combinational during reset; register reads return the reset values.

Verification
REQ-030 Scenario 1: write LOAD=3, then CTRL=0x1 -> COUNT reads 3,2,1,0 on successive clocks; EXPIRED=1 on the 4th edge after the CTRL write; EN reads 0; irq stays 0.
REQ-031 Scenario 2: LOAD=1, CTRL=0x0000_0207 (PRE=2, IE, AUTORELOAD, EN) -> EXPIRED and irq rise 6 clocks after the CTRL write; COUNT reloads to 1; the next expiry follows after another 6 clocks.
REQ-032 Scenario 3: STATUS write 0x1 in the same cycle as expiry -> EXPIRED remains 1; a STATUS write 0x1 one cycle later clears EXPIRED and irq on that edge.
REQ-033 Scenario 4: LOAD write 0x10 in the same cycle as a COUNT==0 tick -> COUNT=0x10 and EXPIRED=0.
REQ-034 Scenario 5: read 0xFFFF1008 -> hit=1, current COUNT; read 0x10000000 -> hit=0, memreaddata=0; write 0xFFFF0000 -> no register changes.
REQ-035 Scenario 6: reset=0 mid-countdown (COUNT=5, EN=1, EXPIRED=1) -> next edge: all registers 0, irq=0; COUNT holds 0 afterward with no further ticks.

Source files
------------

// File: rtl/mips_timer.sv
// mips_timer: memory-mapped countdown timer with prescaler and interrupt.
//
// Register map (base 0xFFFF1000, memaddr[3:2] selects):
//   0x0 CTRL   : bit0 EN, bit1 AUTORELOAD, bit2 IE, bits[15:8] PRE
//   0x4 LOAD   : reload value; writing also loads COUNT and clears the prescaler
//   0x8 COUNT  : current count (read-only)
//   0xC STATUS : bit0 EXPIRED (write-1-to-clear)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   memwrite     bus write strobe
//   memaddr      bus byte address (bits [1:0] unused)
//   memwritedata bus write data
//   memreaddata  combinational read data (0 when not hit)
//   hit          combinational address match for the timer window
//   irq          registered interrupt request (EXPIRED & IE)
module mips_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        hit,
    output logic        irq
);

    logic        en, autoreload, ie;
    logic [7:0]  pre;
    logic [31:0] load;
    logic [31:0] count;
    logic [7:0]  psc;
    logic        expired;

    logic        wr_ctrl, wr_load, wr_status;
    logic        tick, count_zero, expire_set;
    logic        en_next, autoreload_next, ie_next;
    logic [7:0]  pre_next, psc_next;
    logic [31:0] load_next, count_next;
    logic        expired_next;

    assign hit = (memaddr[31:4] == 28'hFFFF100);

    assign wr_ctrl   = memwrite & hit & (memaddr[3:2] == 2'd0);
    assign wr_load   = memwrite & hit & (memaddr[3:2] == 2'd1);
    assign wr_status = memwrite & hit & (memaddr[3:2] == 2'd3);

    always_comb begin
        memreaddata = 32'd0;
        if (hit) begin
            case (memaddr[3:2])
                2'd0:    memreaddata = {16'd0, pre, 5'd0, ie, autoreload, en};
                2'd1:    memreaddata = load;
                2'd2:    memreaddata = count;
                default: memreaddata = {31'd0, expired};
            endcase
        end
    end

    // Tick decisions are made from pre-edge register values; bus writes
    // then override the affected fields at the same edge.
    assign tick       = en & (psc == pre);
    assign count_zero = (count == 32'd0);
    // A LOAD write replaces the tick's effect, so it also suppresses expiry.
    assign expire_set = tick & count_zero & ~wr_load;

    always_comb begin
        autoreload_next = wr_ctrl ? memwritedata[1]    : autoreload;
        ie_next         = wr_ctrl ? memwritedata[2]    : ie;
        pre_next        = wr_ctrl ? memwritedata[15:8] : pre;
        load_next       = wr_load ? memwritedata       : load;

        en_next = en;
        if (wr_ctrl)
            en_next = memwritedata[0];
        else if (expire_set && !autoreload)
            en_next = 1'b0;

        psc_next = psc;
        if (wr_load || !en || tick)
            psc_next = 8'd0;
        else
            psc_next = psc + 8'd1;

        count_next = count;
        if (wr_load)
            count_next = memwritedata;
        else if (tick) begin
            if (!count_zero)
                count_next = count - 32'd1;
            else if (autoreload)
                count_next = load;
            else
                count_next = 32'd0;
        end

        // Set has priority over a same-cycle write-1-to-clear.
        expired_next = expire_set | (expired & ~(wr_status & memwritedata[0]));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            en         <= 1'b0;
            autoreload <= 1'b0;
            ie         <= 1'b0;
            pre        <= 8'd0;
            load       <= 32'd0;
            count      <= 32'd0;
            psc        <= 8'd0;
            expired    <= 1'b0;
            irq        <= 1'b0;
        end else begin
            en         <= en_next;
            autoreload <= autoreload_next;
            ie         <= ie_next;
            pre        <= pre_next;
            load       <= load_next;
            count      <= count_next;
            psc        <= psc_next;
            expired    <= expired_next;
            irq        <= expired_next & ie_next;
        end
    end

endmodule

// File: tb/tb_mips_timer.sv
module tb_mips_timer;

    localparam logic [31:0] A_CTRL   = 32'hFFFF_1000;
    localparam logic [31:0] A_LOAD   = 32'hFFFF_1004;
    localparam logic [31:0] A_COUNT  = 32'hFFFF_1008;
    localparam logic [31:0] A_STATUS = 32'hFFFF_100C;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic        hit;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    mips_timer dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .memaddr      (memaddr),
        .memwritedata (memwritedata),
        .memreaddata  (memreaddata),
        .hit          (hit),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite     = 1'b1;
        memaddr      = a;
        memwritedata = d;
        step();
        memwrite     = 1'b0;
        memwritedata = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        memaddr = a;
        #1;
        d = memreaddata;
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(tag, d, exp);
    endtask

    initial begin
        reset        = 1'b0;
        memwrite     = 1'b0;
        memaddr      = 32'd0;
        memwritedata = 32'd0;
        step();
        step();
        chk_reg("rst_ctrl",   A_CTRL,   32'h0);
        chk_reg("rst_load",   A_LOAD,   32'h0);
        chk_reg("rst_count",  A_COUNT,  32'h0);
        chk_reg("rst_status", A_STATUS, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b1;
        step();

        // Scenario 1: one-shot, PRE=0, LOAD=3
        wr(A_LOAD, 32'd3);
        wr(A_CTRL, 32'h1);
        chk_reg("s1_cnt3", A_COUNT, 32'd3);
        step(); chk_reg("s1_cnt2", A_COUNT, 32'd2);
        step(); chk_reg("s1_cnt1", A_COUNT, 32'd1);
        step(); chk_reg("s1_cnt0", A_COUNT, 32'd0);
        chk_reg("s1_status_pre", A_STATUS, 32'd0);
        step();
        chk_reg("s1_status_set", A_STATUS, 32'd1);
        chk_reg("s1_en_clear",   A_CTRL,   32'h0);
        check("s1_irq", {31'd0, irq}, 32'd0);
        wr(A_STATUS, 32'd0);
        chk_reg("s1_w0_noclr", A_STATUS, 32'd1);
        wr(A_STATUS, 32'd1);
        chk_reg("s1_w1_clr", A_STATUS, 32'd0);
        step();
        chk_reg("s1_cnt_hold", A_COUNT, 32'd0);

        // Scenario 2: PRE=2, LOAD=1, autoreload with interrupt
        wr(A_LOAD, 32'd1);
        wr(A_CTRL, 32'h0000_0207);
        chk_reg("s2_ctrl", A_CTRL, 32'h0000_0207);
        repeat (5) step();
        chk_reg("s2_status_e5", A_STATUS, 32'd0);
        check("s2_irq_e5", {31'd0, irq}, 32'd0);
        step();
        chk_reg("s2_status_e6", A_STATUS, 32'd1);
        check("s2_irq_e6", {31'd0, irq}, 32'd1);
        chk_reg("s2_reload", A_COUNT, 32'd1);

        // Scenario 3: clear collides with the next expiry at E12
        repeat (5) step();
        chk_reg("s3_cnt_e11", A_COUNT, 32'd0);
        wr(A_STATUS, 32'd1);
        chk_reg("s3_set_wins", A_STATUS, 32'd1);
        check("s3_irq_held", {31'd0, irq}, 32'd1);
        chk_reg("s3_reload", A_COUNT, 32'd1);
        wr(A_STATUS, 32'd1);
        chk_reg("s3_cleared", A_STATUS, 32'd0);
        check("s3_irq_clr", {31'd0, irq}, 32'd0);
        wr(A_CTRL, 32'h0);
        step();
        chk_reg("s3_stopped", A_COUNT, 32'd1);

        // Scenario 4: LOAD write overrides a COUNT==0 tick
        wr(A_LOAD, 32'd0);
        wr(A_CTRL, 32'h1);
        wr(A_LOAD, 32'h10);
        chk_reg("s4_count", A_COUNT, 32'h10);
        chk_reg("s4_status", A_STATUS, 32'd0);
        chk_reg("s4_en_kept", A_CTRL, 32'h1);
        // CTRL write clearing EN coincides with a tick: tick still applies
        wr(A_CTRL, 32'h0);
        chk_reg("s4_tick_applied", A_COUNT, 32'h0F);
        chk_reg("s4_en_off", A_CTRL, 32'h0);
        step();
        chk_reg("s4_frozen", A_COUNT, 32'h0F);

        // Scenario 5: decode
        memaddr = A_COUNT; #1;
        check("s5_hit1", {31'd0, hit}, 32'd1);
        check("s5_rd_count", memreaddata, 32'h0F);
        memaddr = 32'h1000_0000; #1;
        check("s5_hit0", {31'd0, hit}, 32'd0);
        check("s5_rd_miss", memreaddata, 32'd0);
        wr(32'hFFFF_0000, 32'h0000_0207);
        chk_reg("s5_miss_ctrl", A_CTRL, 32'h0);
        chk_reg("s5_miss_load", A_LOAD, 32'h10);
        wr(A_COUNT, 32'h99);
        chk_reg("s5_count_ro", A_COUNT, 32'h0F);
        wr(A_CTRL, 32'hFFFF_0308);
        chk_reg("s5_ctrl_mask", A_CTRL, 32'h0000_0300);
        wr(A_CTRL, 32'h0);

        // Scenario 6: PRE=0, LOAD=0, autoreload expires every clock; then reset
        wr(A_LOAD, 32'd0);
        wr(A_CTRL, 32'h3);
        step();
        chk_reg("s6_every_clk", A_STATUS, 32'd1);
        wr(A_CTRL, 32'h5);
        check("s6_irq_on", {31'd0, irq}, 32'd1);
        wr(A_LOAD, 32'd5);
        chk_reg("s6_cnt5", A_COUNT, 32'd5);
        chk_reg("s6_exp1", A_STATUS, 32'd1);
        reset = 1'b0;
        step();
        chk_reg("s6_rst_ctrl",   A_CTRL,   32'h0);
        chk_reg("s6_rst_load",   A_LOAD,   32'h0);
        chk_reg("s6_rst_count",  A_COUNT,  32'h0);
        chk_reg("s6_rst_status", A_STATUS, 32'h0);
        check("s6_rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b1;
        repeat (3) step();
        chk_reg("s6_post_count",  A_COUNT,  32'h0);
        chk_reg("s6_post_status", A_STATUS, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
